ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised next-generation PS/2 device-to-host receiver. It samples the PS/2 clock and data lines through synchronisers, decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and writes {error code, byte} into an internal receive FIFO. Downstream logic pops at its own pace, so it no longer has to catch single-cycle byte strobes. Sits between the PS/2 pins and the mouse/keyboard transaction FSMs.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency; used for timeout derivation.
TIMEOUT_US, 500, maximum gap between PS/2 falling edges inside a frame, in microseconds.
FIFO_DEPTH, 4, receive FIFO entries; must be a power of two, at least 2.
FILTER_LEN, 4, stable-sample count for the optional glitch filter.

Ports:
CLK  in  1  system clock.
RESET  in  1  synchronous, active-high reset.
PS2_CLK_IN  in  1  raw PS/2 clock line (asynchronous).
PS2_DATA_IN  in  1  raw PS/2 data line (asynchronous).
RX_ENABLE  in  1  permits a new frame to start. The host deasserts it while transmitting.
RD_EN  in  1  pops the FIFO head.
RD_DATA  out  8  FIFO head byte (first-word fall-through).
RD_ERR  out  2  FIFO head error code: bit0 is parity error, bit1 is stop-bit error.
RD_VALID  out  1  FIFO is non-empty.
FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  number of entries held.
OVERFLOW  out  1  sticky flag: a frame was dropped because the FIFO was full.
OVF_CLR  in  1  clears OVERFLOW.
TIMEOUT  out  1  one-cycle pulse when a frame is aborted by timeout.

Behaviour:
- Reset values: RD_DATA=0, RD_ERR=0, RD_VALID=0, FIFO_COUNT=0, OVERFLOW=0, TIMEOUT=0, FSM=IDLE, FIFO pointers=0.
- Synchronisation: each PS/2 input passes through a 2-flop synchroniser.
- Edge detect: a falling edge ("fe") is synchronised clock previous=1 and current=0.
- Timeout threshold: TIMEOUT_CYCLES = (CLK_FREQ_HZ/1000000)*TIMEOUT_US.
- Timeout counter: cleared in IDLE and on every fe; otherwise it increments and saturates.
- FSM transitions:
  - IDLE: on fe with data=0 and RX_ENABLE=1, go to DATA with bit count 0. An fe with data=1 is ignored.
  - DATA: on each fe, shift data into bit[count], LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fe, set parity error = (data != ~^byte), i.e. odd parity over the 8 data bits plus the parity bit. Go to STOP.
  - STOP: on fe, set stop error = ~data. Issue a push request and go to IDLE.
  - Any non-IDLE state: if the counter reaches TIMEOUT_CYCLES, go to IDLE, pulse TIMEOUT for 1 cycle, and push nothing.
- Push latency: the entry becomes visible (RD_VALID=1 if the FIFO was empty) on the cycle after the cycle in which the stop-bit fe is detected.
- Push into a full FIFO: drop the entry and set OVERFLOW. Existing contents are untouched.
- Pop: RD_EN with RD_VALID=1 advances the head on the next cycle. RD_EN while empty is ignored.
- Simultaneous push and pop:
  - When full: both occur, count is unchanged, and OVERFLOW is not set.
  - When empty: the push takes effect and the pop is ignored.
- Overflow flag: if OVF_CLR and a new overflow occur in the same cycle, OVERFLOW stays 1 (set wins).
- RX_ENABLE deasserted mid-frame: the frame still completes. RX_ENABLE gates only the start bit.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH. The count distinguishes full from empty.
- RESET mid-frame: FSM returns to IDLE, the partial frame is discarded, and the FIFO is emptied.

Optional Feature:
PS2_RX_GLITCH_FILTER_EN:
- Defined: the synchronised clock feeds a filter whose output changes only after FILTER_LEN consecutive equal samples. This adds FILTER_LEN cycles of edge latency, and a pulse shorter than FILTER_LEN cycles produces no fe. The data line is sampled at the filtered edge.
- Undefined: edge detect runs directly on the 2-flop synchroniser output.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state encoding: IDLE, DATA, PARITY, STOP.
  - Error bit indices: PS2_ERR_PARITY=0, PS2_ERR_STOP=1.
  - PS2_FRAME_BITS=11.
  - A function computing TIMEOUT_CYCLES.
- Sub-module ps2_rx_sync_fifo: generic synchronous FIFO, width 10, depth FIFO_DEPTH, first-word fall-through, with count output. It is reused later by the transmit path.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000000, TIMEOUT_US=500 (500 cycles), FIFO_DEPTH=4, PS/2 clock period 80 cycles.
- Good frame: 0xA5, parity 1, stop 1 -> one entry RD_DATA=0xA5, RD_ERR=00, FIFO_COUNT=1. RD_EN for 1 cycle -> RD_VALID=0.
- Bad parity: 0x3C with parity 0 -> RD_DATA=0x3C, RD_ERR=01.
- Bad stop: 0x3C with parity 1 and stop 0 -> RD_ERR=10.
- Timeout then recovery: start bit plus 4 data bits, then clock held high for 600 cycles -> TIMEOUT pulses once and FIFO_COUNT stays 0. A following 0x12 frame is stored correctly with RD_ERR=00.
- Overflow: 5 frames 0x01..0x05 with no reads -> FIFO_COUNT=4, OVERFLOW=1, pops return 0x01..0x04. OVF_CLR -> OVERFLOW=0. Simultaneous push and pop while full -> count stays 4 and OVERFLOW stays 0.
- Reset and enable: RESET asserted after 3 data bits -> no entry, FSM restarts cleanly on the next frame. RX_ENABLE=0 at the start bit -> frame ignored. RX_ENABLE dropped mid-frame -> frame stored.

Source files
------------

// File: rtl/ps2_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path: frame FSM states, error-code
// bit positions inside a FIFO entry, frame length and the timeout helper.
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2State_t;

  localparam int PS2_ERR_PARITY = 0;
  localparam int PS2_ERR_STOP   = 1;
  localparam int PS2_FRAME_BITS = 11;

  // Number of system clocks allowed between PS/2 falling edges in a frame.
  function automatic int calcTimeoutCycles(input int clkFreqHz, input int timeoutUs);
    return (clkFreqHz / 1000000) * timeoutUs;
  endfunction

endpackage

// File: rtl/ps2_rx_sync_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_sync_fifo
// Generic single-clock FIFO with first-word fall-through and an entry count.
// A write into a full FIFO is accepted only when a read happens in the same
// cycle; a read from an empty FIFO is ignored.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_wrEn, i_wrData    write request and data
//   i_rdEn              pop the head entry
//   o_rdData            head entry (zero while empty)
//   o_valid, o_full     non-empty / full status
//   o_count             number of entries held
// ---------------------------------------------------------------------------
module ps2_rx_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wrEn,
  input  logic [WIDTH-1:0]         i_wrData,
  input  logic                     i_rdEn,
  output logic [WIDTH-1:0]         o_rdData,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_doRead;
  logic w_doWrite;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_doRead  = i_rdEn && !w_empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign w_doWrite = i_wrEn && (!w_full || w_doRead);

  // Storage is not reset; the head output is masked while empty instead.
  always_ff @(posedge i_clk) begin
    if (w_doWrite) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doWrite) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doRead) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doWrite, w_doRead})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdData = w_empty ? '0 : r_mem[r_rdPtr];
  assign o_valid  = !w_empty;
  assign o_full   = w_full;
  assign o_count  = r_count;

endmodule

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
// PS/2 device-to-host receiver. Synchronises the PS/2 clock/data lines,
// decodes 11-bit frames (start, 8 data LSB first, odd parity, stop) and
// stores {error code, byte} in a receive FIFO that downstream logic pops.
// Optional feature macro: PS2_RX_GLITCH_FILTER_EN adds a FILTER_LEN-sample
// stability filter on the synchronised PS/2 clock.
// Ports:
//   CLK, RESET              system clock, synchronous active-high reset
//   PS2_CLK_IN, PS2_DATA_IN raw asynchronous PS/2 lines
//   RX_ENABLE               allows a new frame to start
//   RD_EN                   pop the FIFO head
//   RD_DATA, RD_ERR         head byte and error code (bit0 parity, bit1 stop)
//   RD_VALID, FIFO_COUNT    FIFO non-empty flag and fill level
//   OVERFLOW, OVF_CLR       sticky dropped-frame flag and its clear
//   TIMEOUT                 one-cycle pulse on a frame abort
// ---------------------------------------------------------------------------
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int TIMEOUT_US  = 500,
  parameter int FIFO_DEPTH  = 4,
  parameter int FILTER_LEN  = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          PS2_CLK_IN,
  input  logic                          PS2_DATA_IN,
  input  logic                          RX_ENABLE,
  input  logic                          RD_EN,
  output logic [7:0]                    RD_DATA,
  output logic [1:0]                    RD_ERR,
  output logic                          RD_VALID,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          OVERFLOW,
  input  logic                          OVF_CLR,
  output logic                          TIMEOUT
);

  localparam int TO_CYCLES = calcTimeoutCycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int TO_W      = $clog2(TO_CYCLES + 1);

  logic [1:0]      r_clkSync;
  logic [1:0]      r_dataSync;
  logic            r_clkPrev;
  ps2State_t       r_state;
  logic [2:0]      r_bitCnt;
  logic [7:0]      r_byte;
  logic            r_parErr;
  logic [TO_W-1:0] r_toCnt;
  logic            r_timeout;
  logic            r_overflow;

  logic            w_clkSync;
  logic            w_clkEdge;
  logic            w_data;
  logic            w_fe;
  logic            w_toHit;
  logic            w_push;
  logic [1:0]      w_pushErr;
  logic [9:0]      w_pushData;
  logic [9:0]      w_rdWord;
  logic            w_fifoFull;

  // Lines idle high, so the synchronisers reset to 1 to avoid a fake edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
    end else begin
      r_clkSync  <= {r_clkSync[0], PS2_CLK_IN};
      r_dataSync <= {r_dataSync[0], PS2_DATA_IN};
    end
  end

  assign w_clkSync = r_clkSync[1];
  assign w_data    = r_dataSync[1];

`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  logic [FLT_W-1:0] r_fltCnt;
  logic             r_clkFilt;

  // Filtered clock follows the input only after FILTER_LEN differing samples.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fltCnt  <= '0;
      r_clkFilt <= 1'b1;
    end else if (w_clkSync == r_clkFilt) begin
      r_fltCnt <= '0;
    end else if (r_fltCnt == FLT_W'(FILTER_LEN - 1)) begin
      r_fltCnt  <= '0;
      r_clkFilt <= w_clkSync;
    end else begin
      r_fltCnt <= r_fltCnt + 1'b1;
    end
  end

  assign w_clkEdge = r_clkFilt;
`else
  assign w_clkEdge = w_clkSync;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clkPrev <= 1'b1;
    end else begin
      r_clkPrev <= w_clkEdge;
    end
  end

  assign w_fe    = r_clkPrev && !w_clkEdge;
  assign w_toHit = (r_state != IDLE) && (r_toCnt == TO_W'(TO_CYCLES));

  // Frame FSM plus inter-edge timeout counter; timeout wins over an edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_bitCnt  <= '0;
      r_byte    <= '0;
      r_parErr  <= 1'b0;
      r_toCnt   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == IDLE || w_fe) begin
        r_toCnt <= '0;
      end else if (!w_toHit) begin
        r_toCnt <= r_toCnt + 1'b1;
      end

      if (w_toHit) begin
        r_state   <= IDLE;
        r_timeout <= 1'b1;
      end else if (w_fe) begin
        case (r_state)
          IDLE: begin
            if (!w_data && RX_ENABLE) begin
              r_state  <= DATA;
              r_bitCnt <= '0;
              r_parErr <= 1'b0;
            end
          end
          DATA: begin
            r_byte[r_bitCnt] <= w_data;
            if (r_bitCnt == 3'd7) begin
              r_state <= PARITY;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
          PARITY: begin
            r_parErr <= (w_data != ~^r_byte);
            r_state  <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Push straight from the stop-bit edge so the entry is visible next cycle.
  always_comb begin
    w_pushErr                 = '0;
    w_pushErr[PS2_ERR_PARITY] = r_parErr;
    w_pushErr[PS2_ERR_STOP]   = !w_data;
  end

  assign w_push     = (r_state == STOP) && w_fe && !w_toHit;
  assign w_pushData = {w_pushErr, r_byte};

  ps2_rx_sync_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (CLK),
    .i_reset  (RESET),
    .i_wrEn   (w_push),
    .i_wrData (w_pushData),
    .i_rdEn   (RD_EN),
    .o_rdData (w_rdWord),
    .o_valid  (RD_VALID),
    .o_full   (w_fifoFull),
    .o_count  (FIFO_COUNT)
  );

  // A push into a full FIFO is dropped unless a pop frees a slot that cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_fifoFull && !RD_EN) begin
      r_overflow <= 1'b1;
    end else if (OVF_CLR) begin
      r_overflow <= 1'b0;
    end
  end

  assign RD_DATA  = w_rdWord[7:0];
  assign RD_ERR   = w_rdWord[9:8];
  assign OVERFLOW = r_overflow;
  assign TIMEOUT  = r_timeout;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo
// Directed bench for ps2_rx_fifo. Frames are bit-banged on the PS/2 pins and
// the expected FIFO entries are queued; a monitor pops the DUT whenever it
// holds data and compares against the queue.
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;

  localparam int CLK_HZ = 1000000;
  localparam int TO_US  = 500;
  localparam int DEPTH  = 4;
  localparam int FLT    = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       PS2_CLK_IN;
  logic       PS2_DATA_IN;
  logic       RX_ENABLE;
  logic       RD_EN;
  logic       OVF_CLR;
  logic [7:0] RD_DATA;
  logic [1:0] RD_ERR;
  logic       RD_VALID;
  logic [2:0] FIFO_COUNT;
  logic       OVERFLOW;
  logic       TIMEOUT;

  logic       monRdEn  = 1'b0;
  logic       mainRdEn = 1'b0;
  bit         autoPop  = 1'b0;
  int         nChecks  = 0;
  int         nPass    = 0;
  int         toCount  = 0;
  logic [9:0] expQ[$];

  assign RD_EN = monRdEn | mainRdEn;

  always #5 CLK = ~CLK;

  ps2_rx_fifo #(
    .CLK_FREQ_HZ (CLK_HZ),
    .TIMEOUT_US  (TO_US),
    .FIFO_DEPTH  (DEPTH),
    .FILTER_LEN  (FLT)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PS2_CLK_IN  (PS2_CLK_IN),
    .PS2_DATA_IN (PS2_DATA_IN),
    .RX_ENABLE   (RX_ENABLE),
    .RD_EN       (RD_EN),
    .RD_DATA     (RD_DATA),
    .RD_ERR      (RD_ERR),
    .RD_VALID    (RD_VALID),
    .FIFO_COUNT  (FIFO_COUNT),
    .OVERFLOW    (OVERFLOW),
    .OVF_CLR     (OVF_CLR),
    .TIMEOUT     (TIMEOUT)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic goodPar(input logic [7:0] b);
    return ~^b;
  endfunction

  // Monitor: pops the FIFO whenever it has data and checks the head entry.
  initial begin
    logic [9:0] exp;
    forever begin
      @(posedge CLK);
      #1;
      if (monRdEn) begin
        monRdEn = 1'b0;
      end else if (autoPop && RD_VALID) begin
        if (expQ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL unexpected entry: got 0x%0h, expected none", {RD_ERR, RD_DATA});
        end else begin
          exp = expQ.pop_front();
          checkOutput("pop data", {24'h0, RD_DATA}, {24'h0, exp[7:0]});
          checkOutput("pop err", {30'h0, RD_ERR}, {30'h0, exp[9:8]});
        end
        monRdEn = 1'b1;
      end
    end
  end

  // Counts TIMEOUT high cycles; each abort must contribute exactly one.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (TIMEOUT === 1'b1) toCount++;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Sends the first nBits bits of a frame (80-cycle PS/2 clock period).
  // stopMode 1 checks push latency at the stop edge; stopMode 2 pops the
  // head in the exact cycle the stop edge pushes. dropEnAt clears RX_ENABLE
  // at the start of that bit index.
  task automatic applyStimulus(input logic [7:0] b, input logic par, input logic stp,
                               input int nBits, input int stopMode, input int dropEnAt);
    logic [10:0] bits;
    logic [9:0]  head;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      @(negedge CLK);
      if (i == dropEnAt) RX_ENABLE = 1'b0;
      PS2_DATA_IN = bits[i];
      repeat (20) @(negedge CLK);
      PS2_CLK_IN = 1'b0;
      if (i == 10 && stopMode != 0) begin
        @(posedge CLK);
        @(posedge CLK);
        #1;
        if (stopMode == 1) begin
          checkOutput("latency before push", {31'h0, RD_VALID}, 32'h0);
          @(posedge CLK);
          #1;
          checkOutput("latency after push", {31'h0, RD_VALID}, 32'h1);
        end else begin
          head = expQ.pop_front();
          checkOutput("full head data", {24'h0, RD_DATA}, {24'h0, head[7:0]});
          mainRdEn = 1'b1;
          @(posedge CLK);
          #1;
          mainRdEn = 1'b0;
        end
        repeat (37) @(negedge CLK);
      end else begin
        repeat (40) @(negedge CLK);
      end
      PS2_CLK_IN = 1'b1;
      repeat (19) @(negedge CLK);
    end
    PS2_DATA_IN = 1'b1;
  endtask

  // Lets the monitor empty the FIFO; an expired bound counts as a failure.
  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || RD_VALID) && n < 300) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 300) begin
      nChecks++;
      $display("[TB] FAIL %s drain: got %0d pending, expected 0", name, expQ.size());
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    int t0;
    RESET       = 1'b1;
    PS2_CLK_IN  = 1'b1;
    PS2_DATA_IN = 1'b1;
    RX_ENABLE   = 1'b1;
    OVF_CLR     = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset RD_DATA", {24'h0, RD_DATA}, 32'h0);
    checkOutput("reset RD_ERR", {30'h0, RD_ERR}, 32'h0);
    checkOutput("reset RD_VALID", {31'h0, RD_VALID}, 32'h0);
    checkOutput("reset FIFO_COUNT", {29'h0, FIFO_COUNT}, 32'h0);
    checkOutput("reset OVERFLOW", {31'h0, OVERFLOW}, 32'h0);
    checkOutput("reset TIMEOUT", {31'h0, TIMEOUT}, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    // Good frame, held until counted, then popped by the monitor.
    $display("[TB] good frame 0xA5");
    expQ.push_back({2'b00, 8'hA5});
    applyStimulus(8'hA5, 1'b1, 1'b1, 11, 1, -1);
    checkOutput("good count", {29'h0, FIFO_COUNT}, 32'h1);
    autoPop = 1'b1;
    waitDrain("good");
    checkOutput("good valid after pop", {31'h0, RD_VALID}, 32'h0);
    checkOutput("good count after pop", {29'h0, FIFO_COUNT}, 32'h0);

    $display("[TB] parity and stop errors");
    expQ.push_back({2'b01, 8'h3C});
    applyStimulus(8'h3C, 1'b0, 1'b1, 11, 0, -1);
    waitDrain("bad parity");
    expQ.push_back({2'b10, 8'h3C});
    applyStimulus(8'h3C, 1'b1, 1'b0, 11, 0, -1);
    waitDrain("bad stop");

    $display("[TB] timeout and recovery");
    t0 = toCount;
    applyStimulus(8'h00, 1'b0, 1'b1, 5, 0, -1);
    repeat (600) @(negedge CLK);
    checkOutput("timeout pulses", t0 == toCount ? 32'h0 : 32'(toCount - t0), 32'h1);
    checkOutput("timeout count", {29'h0, FIFO_COUNT}, 32'h0);
    expQ.push_back({2'b00, 8'h12});
    applyStimulus(8'h12, 1'b1, 1'b1, 11, 0, -1);
    waitDrain("recovery");

    $display("[TB] overflow");
    autoPop = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= DEPTH) expQ.push_back({2'b00, 8'(v)});
      applyStimulus(8'(v), goodPar(8'(v)), 1'b1, 11, 0, -1);
    end
    checkOutput("overflow count", {29'h0, FIFO_COUNT}, 32'h4);
    checkOutput("overflow flag", {31'h0, OVERFLOW}, 32'h1);
    checkOutput("overflow head kept", {24'h0, RD_DATA}, 32'h01);
    @(negedge CLK);
    OVF_CLR = 1'b1;
    @(negedge CLK);
    OVF_CLR = 1'b0;
    checkOutput("overflow cleared", {31'h0, OVERFLOW}, 32'h0);
    expQ.push_back({2'b00, 8'h06});
    applyStimulus(8'h06, goodPar(8'h06), 1'b1, 11, 2, -1);
    checkOutput("push+pop full count", {29'h0, FIFO_COUNT}, 32'h4);
    checkOutput("push+pop full ovf", {31'h0, OVERFLOW}, 32'h0);
    autoPop = 1'b1;
    waitDrain("overflow");

    $display("[TB] reset mid-frame");
    autoPop = 1'b0;
    applyStimulus(8'h77, 1'b1, 1'b1, 11, 0, -1);
    checkOutput("pre-reset count", {29'h0, FIFO_COUNT}, 32'h1);
    applyStimulus(8'h00, 1'b0, 1'b1, 4, 0, -1);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    checkOutput("post-reset count", {29'h0, FIFO_COUNT}, 32'h0);
    checkOutput("post-reset valid", {31'h0, RD_VALID}, 32'h0);
    autoPop = 1'b1;
    expQ.push_back({2'b00, 8'h5A});
    applyStimulus(8'h5A, 1'b1, 1'b1, 11, 0, -1);
    waitDrain("after reset");

    $display("[TB] RX_ENABLE gating");
    RX_ENABLE = 1'b0;
    applyStimulus(8'h33, 1'b1, 1'b1, 11, 0, -1);
    RX_ENABLE = 1'b1;
    repeat (20) @(negedge CLK);
    checkOutput("disabled frame count", {29'h0, FIFO_COUNT}, 32'h0);
    expQ.push_back({2'b00, 8'h81});
    applyStimulus(8'h81, 1'b1, 1'b1, 11, 0, 3);
    RX_ENABLE = 1'b1;
    waitDrain("enable dropped");

    checkOutput("total timeout pulses", 32'(toCount), 32'h1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
